// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART core.
// Holds the TX/RX state enums, data/idle constants and the clocks-per-bit helper.
// Optional feature macro: UART_PARITY_EN adds the parity state to both enums.
package uart_pkg;

  localparam int unsigned DATA_BITS  = 8;
  localparam logic        IDLE_LEVEL = 1'b1;

`ifdef UART_PARITY_EN
  typedef enum logic [2:0] {TxIdle, TxStart, TxData, TxParity, TxStop} tx_state_e;
  typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxParity, RxStop} rx_state_e;
`else
  typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_e;
  typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;
`endif

  // Rounded division so the bit period is as close to the line rate as possible.
  function automatic int unsigned clks_per_bit(int unsigned clk_freq, int unsigned baud);
    return (clk_freq + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_rx.sv
// uart_rx: UART receiver. Synchronises rxd, detects the start edge, samples each bit at
// mid-period and reports the byte or a framing/parity error.
// Ports:
//   clock  - system clock (rising edge)
//   reset  - synchronous active-high reset
//   rxd    - asynchronous serial input, idle high
//   rx     - last correctly received byte
//   rxce   - one-cycle pulse when rx has been loaded
//   frmero - one-cycle pulse on a bad stop bit (or parity mismatch)
// Optional feature macro: UART_PARITY_EN (even-parity bit checked before the stop bit).
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx,
  output logic                 rxce,
  output logic                 frmero
);

  localparam int unsigned     CntW    = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] CntMax  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] CntHalf = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0]      BitMax  = 3'(DATA_BITS - 1);

  logic [1:0]           sync_q;
  logic                 rxd_prev_q;
  logic                 rxd_s;
  rx_state_e            state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] rx_q, rx_d;
  logic                 rxce_q, rxce_d;
  logic                 frmero_q, frmero_d;
  logic                 stop_wait_q, stop_wait_d;
  logic                 par_bad;

  assign rxd_s = sync_q[1];

`ifdef UART_PARITY_EN
  logic par_err_q, par_err_d;
  assign par_bad = par_err_q;

  always_ff @(posedge clock) begin
    if (reset) par_err_q <= 1'b0;
    else       par_err_q <= par_err_d;
  end
`else
  assign par_bad = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      // Synchroniser resets to the idle level so reset release never looks like a start edge.
      sync_q      <= {2{IDLE_LEVEL}};
      rxd_prev_q  <= IDLE_LEVEL;
      state_q     <= RxIdle;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      rx_q        <= '0;
      rxce_q      <= 1'b0;
      frmero_q    <= 1'b0;
      stop_wait_q <= 1'b0;
    end else begin
      sync_q      <= {sync_q[0], rxd};
      rxd_prev_q  <= rxd_s;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      rx_q        <= rx_d;
      rxce_q      <= rxce_d;
      frmero_q    <= frmero_d;
      stop_wait_q <= stop_wait_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    rx_d        = rx_q;
    rxce_d      = 1'b0;
    frmero_d    = 1'b0;
    stop_wait_d = stop_wait_q;
`ifdef UART_PARITY_EN
    par_err_d   = par_err_q;
`endif
    unique case (state_q)
      RxIdle: begin
        cnt_d       = '0;
        bit_idx_d   = '0;
        stop_wait_d = 1'b0;
        if (rxd_prev_q && !rxd_s) state_d = RxStart;
      end
      RxStart: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntHalf) begin
          cnt_d   = '0;
          // A line back high at mid start bit was a glitch, not a frame.
          state_d = rxd_s ? RxIdle : RxData;
        end
      end
      RxData: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntMax) begin
          cnt_d     = '0;
          shift_d   = {rxd_s, shift_q[DATA_BITS-1:1]};
          bit_idx_d = bit_idx_q + 1'b1;
`ifdef UART_PARITY_EN
          if (bit_idx_q == BitMax) state_d = RxParity;
`else
          if (bit_idx_q == BitMax) state_d = RxStop;
`endif
        end
      end
`ifdef UART_PARITY_EN
      RxParity: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntMax) begin
          cnt_d     = '0;
          par_err_d = rxd_s ^ (^shift_q);
          state_d   = RxStop;
        end
      end
`endif
      RxStop: begin
        if (stop_wait_q) begin
          // Bad stop bit already reported; hold off until the line returns to idle.
          cnt_d = '0;
          if (rxd_s) state_d = RxIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CntMax) begin
            cnt_d = '0;
            if (!rxd_s) begin
              frmero_d    = 1'b1;
              stop_wait_d = 1'b1;
            end else if (par_bad) begin
              frmero_d = 1'b1;
              state_d  = RxIdle;
            end else begin
              rx_d    = shift_q;
              rxce_d  = 1'b1;
              state_d = RxIdle;
            end
          end
        end
      end
      default: state_d = RxIdle;
    endcase
  end

  assign rx     = rx_q;
  assign rxce   = rxce_q;
  assign frmero = frmero_q;

endmodule

// File: rtl/uart_core.sv
// uart_core: full-duplex 8-bit UART (8N1, or 8E1 with UART_PARITY_EN defined).
// The transmit FSM lives here; the receiver is the uart_rx sub-module.
// Ports:
//   clock    - system clock (rising edge)
//   reset    - synchronous active-high reset
//   rxd      - asynchronous serial input, idle high
//   txd      - serial output, idle high
//   txce     - transmit strobe, accepted only while idle
//   tx       - byte to transmit, latched on an accepted txce
//   rxce     - one-cycle pulse: rx holds a new byte
//   rx       - last correctly received byte
//   bsy      - transmitter busy (txce ignored)
//   transmit - high during start and data bits
//   frmero   - one-cycle pulse on framing (or parity) error
// Optional feature macro: UART_PARITY_EN.
module uart_core
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ     = 50_000_000,
  parameter int unsigned BAUD         = 115200,
  parameter int unsigned CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 rxd,
  output logic                 txd,
  input  logic                 txce,
  input  logic [DATA_BITS-1:0] tx,
  output logic                 rxce,
  output logic [DATA_BITS-1:0] rx,
  output logic                 bsy,
  output logic                 transmit,
  output logic                 frmero
);

  localparam int unsigned     CntW   = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]      BitMax = 3'(DATA_BITS - 1);

  tx_state_e            tx_state_q, tx_state_d;
  logic [CntW-1:0]      tx_cnt_q, tx_cnt_d;
  logic [2:0]           tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
  logic                 tx_bit_end;

  assign tx_bit_end = (tx_cnt_q == CntMax);

  always_ff @(posedge clock) begin
    if (reset) begin
      tx_state_q <= TxIdle;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    if (tx_state_q != TxIdle) tx_cnt_d = tx_bit_end ? '0 : tx_cnt_q + 1'b1;
    unique case (tx_state_q)
      TxIdle: begin
        if (txce) begin
          tx_shift_d = tx;
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_state_d = TxStart;
        end
      end
      TxStart: if (tx_bit_end) tx_state_d = TxData;
      TxData: begin
        if (tx_bit_end) begin
          // Rotate rather than shift: the byte is intact again after 8 bits for the parity bit.
          tx_shift_d = {tx_shift_q[0], tx_shift_q[DATA_BITS-1:1]};
          tx_bit_d   = tx_bit_q + 1'b1;
`ifdef UART_PARITY_EN
          if (tx_bit_q == BitMax) tx_state_d = TxParity;
`else
          if (tx_bit_q == BitMax) tx_state_d = TxStop;
`endif
        end
      end
`ifdef UART_PARITY_EN
      TxParity: if (tx_bit_end) tx_state_d = TxStop;
`endif
      TxStop: if (tx_bit_end) tx_state_d = TxIdle;
      default: tx_state_d = TxIdle;
    endcase
  end

  always_comb begin
    txd      = IDLE_LEVEL;
    transmit = 1'b0;
    unique case (tx_state_q)
      TxStart: begin
        txd      = 1'b0;
        transmit = 1'b1;
      end
      TxData: begin
        txd      = tx_shift_q[0];
        transmit = 1'b1;
      end
`ifdef UART_PARITY_EN
      TxParity: txd = ^tx_shift_q;
`endif
      default: ;
    endcase
  end

  assign bsy = (tx_state_q != TxIdle);

  uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clock (clock),
    .reset (reset),
    .rxd   (rxd),
    .rx    (rx),
    .rxce  (rxce),
    .frmero(frmero)
  );

endmodule

// File: tb/tb_uart_core.sv
module tb_uart_core;

  localparam int unsigned CLK_FREQ = 50_000_000;
  localparam int unsigned BAUD     = 115200;
  localparam int          CPB      = int'((CLK_FREQ + BAUD / 2) / BAUD);
`ifdef UART_PARITY_EN
  localparam int          FRAME_BITS = 11;
`else
  localparam int          FRAME_BITS = 10;
`endif

  typedef struct {
    logic [7:0] data;
    logic       stop_bit;
    int         exp_rxce;
    int         exp_frm;
    logic [7:0] exp_rx;
  } rx_vec_t;

  logic       clock   = 1'b0;
  logic       reset   = 1'b1;
  logic       txce    = 1'b0;
  logic [7:0] tx      = 8'h00;
  logic       rxd_drv = 1'b1;
  logic       loop_en = 1'b0;
  logic       rxd;
  logic       txd, rxce, bsy, transmit, frmero;
  logic [7:0] rx;

  int checks   = 0;
  int errors   = 0;
  int rxce_cnt = 0;
  int frm_cnt  = 0;
  int both_cnt = 0;

  rx_vec_t vecs[4];

  always #5 clock = ~clock;

  always_comb rxd = loop_en ? txd : rxd_drv;

  uart_core dut (
    .clock   (clock),
    .reset   (reset),
    .rxd     (rxd),
    .txd     (txd),
    .txce    (txce),
    .tx      (tx),
    .rxce    (rxce),
    .rx      (rx),
    .bsy     (bsy),
    .transmit(transmit),
    .frmero  (frmero)
  );

  always @(negedge clock) begin
    if (!reset) begin
      if (rxce) rxce_cnt++;
      if (frmero) frm_cnt++;
      if (rxce && frmero) both_cnt++;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h required %0h", name, act, exp);
    end
  endtask

  // Expected line levels of one frame, bit 0 first: start, data LSB first, [parity], stop.
  function automatic logic [FRAME_BITS-1:0] model_frame(input logic [7:0] d);
    logic [FRAME_BITS-1:0] f;
    f    = '1;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[1 + i] = d[i];
`ifdef UART_PARITY_EN
    f[9] = ($countones(d) % 2) == 1;
`endif
    return f;
  endfunction

  task automatic send_tx(input logic [7:0] data, input bit junk, input string tag);
    logic [FRAME_BITS-1:0] got, exp;
    int bsy_len, trn_len;
    exp     = model_frame(data);
    got     = '0;
    bsy_len = 0;
    trn_len = 0;
    tx   = data;
    txce = 1'b1;
    tick();
    txce = 1'b0;
    check({tag, "_first_cycle"}, 32'({txd, bsy, transmit}), 32'b011);
    for (int c = 0; c < FRAME_BITS * CPB + 20; c++) begin
      if ((c % CPB) == CPB / 2 && c < FRAME_BITS * CPB) got[c / CPB] = txd;
      if (bsy) bsy_len++;
      if (transmit) trn_len++;
      if (junk && c == 1000) begin
        tx   = 8'hFF;
        txce = 1'b1;
      end else begin
        txce = 1'b0;
      end
      tick();
    end
    check({tag, "_bits"}, 32'(got), 32'(exp));
    check({tag, "_bsy_len"}, 32'(bsy_len), 32'(FRAME_BITS * CPB));
    check({tag, "_transmit_len"}, 32'(trn_len), 32'(9 * CPB));
    check({tag, "_idle_after"}, 32'({txd, bsy, transmit}), 32'b100);
  endtask

  task automatic drive_rx(input logic [7:0] data, input logic stop_bit);
    logic [FRAME_BITS-1:0] bits;
    bits = model_frame(data);
    bits[FRAME_BITS-1] = stop_bit;
    for (int b = 0; b < FRAME_BITS; b++) begin
      rxd_drv = bits[b];
      repeat (CPB) tick();
    end
    rxd_drv = 1'b1;
    repeat (CPB) tick();
  endtask

  initial begin
    int base_rxce, base_frm;
    logic [7:0] model_rx;

    vecs[0] = '{data: 8'h55, stop_bit: 1'b0, exp_rxce: 0, exp_frm: 1, exp_rx: 8'h00};
    vecs[1] = '{data: 8'h0F, stop_bit: 1'b1, exp_rxce: 1, exp_frm: 0, exp_rx: 8'h0F};
    vecs[2] = '{data: 8'hC3, stop_bit: 1'b0, exp_rxce: 0, exp_frm: 1, exp_rx: 8'h0F};
    vecs[3] = '{data: 8'h80, stop_bit: 1'b1, exp_rxce: 1, exp_frm: 0, exp_rx: 8'h80};

    reset = 1'b1;
    repeat (5) tick();
    check("reset_txd", 32'(txd), 32'd1);
    check("reset_bsy", 32'(bsy), 32'd0);
    check("reset_transmit", 32'(transmit), 32'd0);
    check("reset_rxce", 32'(rxce), 32'd0);
    check("reset_rx", 32'(rx), 32'h00);
    check("reset_frmero", 32'(frmero), 32'd0);
    reset = 1'b0;
    tick();

    send_tx(8'hA5, 1'b0, "tx_a5");

    loop_en   = 1'b1;
    base_rxce = rxce_cnt;
    base_frm  = frm_cnt;
    send_tx(8'h3C, 1'b0, "loop_3c");
    check("loop_3c_rxce", 32'(rxce_cnt - base_rxce), 32'd1);
    check("loop_3c_frmero", 32'(frm_cnt - base_frm), 32'd0);
    check("loop_3c_rx", 32'(rx), 32'h3C);

    // Reset in the middle of a looped-back frame aborts both directions.
    tx   = 8'h81;
    txce = 1'b1;
    tick();
    txce = 1'b0;
    repeat (1000) tick();
    reset = 1'b1;
    tick();
    check("midreset_outputs", 32'({txd, bsy, transmit, rxce, frmero}), 32'b10000);
    check("midreset_rx", 32'(rx), 32'h00);
    repeat (4) tick();
    reset     = 1'b0;
    base_rxce = rxce_cnt;
    base_frm  = frm_cnt;
    repeat (4000) tick();
    check("midreset_no_partial", 32'({rxce_cnt - base_rxce, frm_cnt - base_frm}), 32'd0);
    check("midreset_txd_idle", 32'({txd, bsy}), 32'b10);
    loop_en = 1'b0;

    foreach (vecs[i]) begin
      base_rxce = rxce_cnt;
      base_frm  = frm_cnt;
      drive_rx(vecs[i].data, vecs[i].stop_bit);
      check($sformatf("rxvec%0d_rxce", i), 32'(rxce_cnt - base_rxce), 32'(vecs[i].exp_rxce));
      check($sformatf("rxvec%0d_frmero", i), 32'(frm_cnt - base_frm), 32'(vecs[i].exp_frm));
      check($sformatf("rxvec%0d_rx", i), 32'(rx), 32'(vecs[i].exp_rx));
    end

    base_rxce = rxce_cnt;
    base_frm  = frm_cnt;
    rxd_drv   = 1'b0;
    repeat (100) tick();
    rxd_drv = 1'b1;
    repeat (CPB) tick();
    check("glitch_rxce", 32'(rxce_cnt - base_rxce), 32'd0);
    check("glitch_frmero", 32'(frm_cnt - base_frm), 32'd0);
    drive_rx(8'h6E, 1'b1);
    check("after_glitch_rxce", 32'(rxce_cnt - base_rxce), 32'd1);
    check("after_glitch_frmero", 32'(frm_cnt - base_frm), 32'd0);
    check("after_glitch_rx", 32'(rx), 32'h6E);

    send_tx(8'h12, 1'b1, "busy_drop");

    loop_en = 1'b1;
    for (int n = 0; n < 3; n++) begin
      model_rx  = 8'($urandom_range(0, 255));
      base_rxce = rxce_cnt;
      base_frm  = frm_cnt;
      send_tx(model_rx, 1'b0, $sformatf("rand%0d", n));
      check($sformatf("rand%0d_rxce", n), 32'(rxce_cnt - base_rxce), 32'd1);
      check($sformatf("rand%0d_frmero", n), 32'(frm_cnt - base_frm), 32'd0);
      check($sformatf("rand%0d_rx", n), 32'(rx), 32'(model_rx));
    end
    loop_en = 1'b0;

    check("rxce_frmero_overlap", 32'(both_cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
